teletext_frame_feeder: RTL

- Mode-7 display front end that drives the SAA5050-style character generator from the other side of its interface.
- Generates the character-rate strobe (F1), the pixel-shift strobe (T6), and the HSYNC, VSYNC, LOSE and CHAR_ROUND timing.
- Reads character codes from a 1 KB teletext page RAM and presents them on a 7-bit DATABUS, aligned with LOSE.
- Sits between the video RAM arbiter and the character generator.

---
 rtl/teletext_pkg.sv | 42 ++++
 rtl/teletext_strobe_gen.sv | 48 ++++
 rtl/teletext_frame_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/teletext_pkg.sv
// teletext_pkg
//   Shared constants and helpers for the Mode-7 teletext display front end.
//   Holds the default raster geometry, the page RAM address width, the
//   character code used for blanked positions and the page address
//   arithmetic shared by the frame feeder.
package teletext_pkg;

  // Page RAM and character bus geometry
  localparam int PAGE_ADDR_W = 10;
  localparam int CHAR_W      = 7;

  typedef logic [PAGE_ADDR_W-1:0] page_addr_t;
  typedef logic [CHAR_W-1:0]      char_code_t;

  // Blank character shown whenever the beam is outside the displayed window
  localparam char_code_t SPACE_CODE = 7'h20;

  // Default raster timing (12 MHz CLK, 1 MHz character rate)
  localparam int DEF_CLK_DIV          = 12;
  localparam int DEF_H_TOTAL          = 64;
  localparam int DEF_H_DISPLAYED      = 40;
  localparam int DEF_HSYNC_POS        = 51;
  localparam int DEF_HSYNC_WIDTH      = 4;
  localparam int DEF_SCANLINES        = 10;
  localparam int DEF_V_ROWS_TOTAL     = 31;
  localparam int DEF_V_ROWS_DISPLAYED = 25;
  localparam int DEF_VSYNC_ROW        = 27;
  localparam int DEF_VSYNC_LINES      = 2;

  // Page address of character (row, h) relative to base. The sum is formed
  // wide and truncated, so a page placed near the top of the 1 KB RAM wraps
  // round to address 0 instead of saturating.
  function automatic page_addr_t page_addr(input page_addr_t base,
                                           input int unsigned row,
                                           input int unsigned h,
                                           input int unsigned disp_w);
    logic [31:0] sum;
    sum = 32'(base) + (row * disp_w) + h;
    return sum[PAGE_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/teletext_strobe_gen.sv
// teletext_strobe_gen
//   Character-rate divider for the teletext front end. A free-running
//   counter div steps 0..CLK_DIV-1; both strobes are registered so they are
//   glitch-free toward the character generator.
//     F1 : high for one CLK when div == CLK_DIV-1 (character load)
//     T6 : high on odd div values other than CLK_DIV-1 (pixel shift)
//   CLK_DIV must be even and at least 4; the F1 slot then always lands on
//   an odd count, so F1 and T6 can never coincide.
// Ports
//   CLK     in  system clock
//   nRESET  in  asynchronous active-low reset
//   F1      out character strobe
//   T6      out pixel-shift strobe
module teletext_strobe_gen
  import teletext_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic CLK,
  input  logic nRESET,
  output logic F1,
  output logic T6
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_p0;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = (div_p0 == DIV_LAST) ? '0 : div_p0 + 1'b1;
  end

  // Strobes are decoded from the next count so they line up with div_p0
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      div_p0 <= '0;
      F1     <= 1'b0;
      T6     <= 1'b0;
    end else begin
      div_p0 <= div_nxt;
      F1     <= (div_nxt == DIV_LAST);
      T6     <= div_nxt[0] && (div_nxt != DIV_LAST);
    end
  end

endmodule

// File: rtl/teletext_frame_feeder.sv
// teletext_frame_feeder
//   Mode-7 display front end feeding an SAA5050-style character generator.
//   Walks the raster (character h, scanline sl, character row), fetches the
//   character codes of a 1 KB teletext page and presents them on DATABUS
//   together with LOSE, HSYNC and VSYNC, all mutually aligned.
//
//   Two stages, both advancing only on F1:
//     p0 : raster position of the character being fetched; ADDR is issued
//          for it and the page RAM answers on RDATA one CLK later.
//     p1 : the port registers DATABUS/LOSE/HSYNC/VSYNC, loaded on the next
//          F1 from RDATA and the p0 position, i.e. one character after ADDR.
//   Every non-strobe output therefore changes only in the CLK after F1 and
//   is stable when the character generator samples it on its next F1.
//
//   After reset the first F1 enters the frame at h=sl=row=0 rather than
//   stepping past it, so the first character of the frame is fetched with
//   the freshly sampled START_ADDR.
// Ports
//   CLK         in  system clock
//   nRESET      in  asynchronous active-low reset
//   START_ADDR  in  page base address, sampled at frame start
//   RDATA       in  page RAM read data, valid one CLK after ADDR
//   ADDR        out page RAM read address
//   F1          out character strobe
//   T6          out pixel-shift strobe
//   DATABUS     out character code to the character generator
//   LOSE        out display enable, aligned with DATABUS
//   HSYNC       out horizontal sync, active high
//   VSYNC       out vertical sync, active high
//   CHAR_ROUND  out field parity, toggles every frame
module teletext_frame_feeder
  import teletext_pkg::*;
#(
  parameter int CLK_DIV          = DEF_CLK_DIV,
  parameter int H_TOTAL          = DEF_H_TOTAL,
  parameter int H_DISPLAYED      = DEF_H_DISPLAYED,
  parameter int HSYNC_POS        = DEF_HSYNC_POS,
  parameter int HSYNC_WIDTH      = DEF_HSYNC_WIDTH,
  parameter int SCANLINES        = DEF_SCANLINES,
  parameter int V_ROWS_TOTAL     = DEF_V_ROWS_TOTAL,
  parameter int V_ROWS_DISPLAYED = DEF_V_ROWS_DISPLAYED,
  parameter int VSYNC_ROW        = DEF_VSYNC_ROW,
  parameter int VSYNC_LINES      = DEF_VSYNC_LINES
) (
  input  logic                   CLK,
  input  logic                   nRESET,
  input  logic [PAGE_ADDR_W-1:0] START_ADDR,
  input  logic [CHAR_W-1:0]      RDATA,
  output logic [PAGE_ADDR_W-1:0] ADDR,
  output logic                   F1,
  output logic                   T6,
  output logic [CHAR_W-1:0]      DATABUS,
  output logic                   LOSE,
  output logic                   HSYNC,
  output logic                   VSYNC,
  output logic                   CHAR_ROUND
);

  localparam int H_W   = $clog2(H_TOTAL);
  localparam int SL_W  = $clog2(SCANLINES);
  localparam int ROW_W = $clog2(V_ROWS_TOTAL);

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [SL_W-1:0]  SL_LAST  = SL_W'(SCANLINES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ROWS_TOTAL - 1);

  // Raster window decoders, evaluated on plain integer positions
  function automatic logic is_disp(input int hc, input int rc);
    return (hc < H_DISPLAYED) && (rc < V_ROWS_DISPLAYED);
  endfunction

  function automatic logic in_hsync(input int hc);
    return (hc >= HSYNC_POS) && (hc < HSYNC_POS + HSYNC_WIDTH);
  endfunction

  function automatic logic in_vsync(input int slc, input int rc);
    return (rc == VSYNC_ROW) && (slc < VSYNC_LINES);
  endfunction

  // Character strobes
  teletext_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .CLK    (CLK),
    .nRESET (nRESET),
    .F1     (F1),
    .T6     (T6)
  );

  // p0 state: position of the character whose code is being fetched
  logic             primed;
  logic [H_W-1:0]   h_p0;
  logic [SL_W-1:0]  sl_p0;
  logic [ROW_W-1:0] row_p0;
  page_addr_t       base_p0;
  logic             vld_p0;

  // Position entering on the next F1
  logic [H_W-1:0]   h_nxt;
  logic [SL_W-1:0]  sl_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             frame_start;
  page_addr_t       base_nxt;
  page_addr_t       addr_nxt;
  logic             disp_nxt;

  always_comb begin
    h_nxt   = h_p0;
    sl_nxt  = sl_p0;
    row_nxt = row_p0;
    if (!primed) begin
      h_nxt   = '0;
      sl_nxt  = '0;
      row_nxt = '0;
    end else if (h_p0 == H_LAST) begin
      h_nxt = '0;
      if (sl_p0 == SL_LAST) begin
        sl_nxt  = '0;
        row_nxt = (row_p0 == ROW_LAST) ? '0 : row_p0 + 1'b1;
      end else begin
        sl_nxt = sl_p0 + 1'b1;
      end
    end else begin
      h_nxt = h_p0 + 1'b1;
    end

    frame_start = (h_nxt == '0) && (sl_nxt == '0) && (row_nxt == '0);
    base_nxt    = frame_start ? START_ADDR : base_p0;
    disp_nxt    = is_disp(32'(h_nxt), 32'(row_nxt));
    addr_nxt    = page_addr(base_nxt, 32'(row_nxt), 32'(h_nxt),
                            H_DISPLAYED);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      primed     <= 1'b0;
      h_p0       <= '0;
      sl_p0      <= '0;
      row_p0     <= '0;
      base_p0    <= '0;
      vld_p0     <= 1'b0;
      ADDR       <= '0;
      CHAR_ROUND <= 1'b0;
      DATABUS    <= SPACE_CODE;
      LOSE       <= 1'b0;
      HSYNC      <= 1'b0;
      VSYNC      <= 1'b0;
    end else if (F1) begin
      // p0: advance raster position and issue the next fetch
      primed  <= 1'b1;
      h_p0    <= h_nxt;
      sl_p0   <= sl_nxt;
      row_p0  <= row_nxt;
      base_p0 <= base_nxt;
      vld_p0  <= disp_nxt;
      if (disp_nxt) begin
        ADDR <= addr_nxt;
      end
      if (frame_start) begin
        CHAR_ROUND <= ~CHAR_ROUND;
      end
      // p1: present the character fetched during the previous period
      DATABUS <= vld_p0 ? RDATA : SPACE_CODE;
      LOSE    <= vld_p0;
      HSYNC   <= primed && in_hsync(32'(h_p0));
      VSYNC   <= primed && in_vsync(32'(sl_p0), 32'(row_p0));
    end
  end

endmodule
